// File: rtl/qspi_pkg.sv
// Shared constants, state encoding and helpers for the QSPI PSRAM target.
package qspi_pkg;

  localparam logic [7:0] CMD_ENTER_QUAD = 8'h35;
  localparam logic [7:0] CMD_QREAD      = 8'hEB;
  localparam logic [7:0] CMD_QWRITE     = 8'h38;

  localparam int ADDR_NIBBLES = 6;
  localparam int CNT_W        = 8;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_IGNORE
  } qspi_state_e;

  // Nibble i of a 16-bit word, nibble 0 being the most significant.
  function automatic logic [3:0] nib_sel(input logic [15:0] w, input logic [1:0] i);
    case (i)
      2'd0:    nib_sel = w[15:12];
      2'd1:    nib_sel = w[11:8];
      2'd2:    nib_sel = w[7:4];
      default: nib_sel = w[3:0];
    endcase
  endfunction

endpackage

// File: rtl/qspi_pin_sync.sv
// 2-FF synchronisers for the QSPI pins plus SCK edge detection in the clk domain.
module qspi_pin_sync (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_sck,
  input  logic       i_ncs,
  input  logic [3:0] i_data,
  output logic       o_sck_rise,
  output logic       o_sck_fall,
  output logic       o_ncs,
  output logic [3:0] o_data
);

  logic [1:0] r_sck_s;
  logic [1:0] r_ncs_s;
  logic [3:0] r_dat_s0, r_dat_s1;
  logic       r_sck_q;

  // Synchroniser chains; NCS idles high so it resets to deselected.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sck_s  <= 2'b00;
      r_ncs_s  <= 2'b11;
      r_dat_s0 <= 4'h0;
      r_dat_s1 <= 4'h0;
      r_sck_q  <= 1'b0;
    end else begin
      r_sck_s  <= {r_sck_s[0], i_sck};
      r_ncs_s  <= {r_ncs_s[0], i_ncs};
      r_dat_s0 <= i_data;
      r_dat_s1 <= r_dat_s0;
      r_sck_q  <= r_sck_s[1];
    end
  end

  assign o_sck_rise = r_sck_s[1] & ~r_sck_q;
  assign o_sck_fall = ~r_sck_s[1] & r_sck_q;
  assign o_ncs      = r_ncs_s[1];
  assign o_data     = r_dat_s1;

endmodule

// File: rtl/qspi_psram_target.sv
// Quad-mode PSRAM emulator: decodes 0x35/0xEB/0x38 and drives a word-memory port.
import qspi_pkg::*;

module qspi_psram_target #(
  parameter int ASZ   = 22,
  parameter int DSZ   = 16,
  parameter int DUMMY = 6
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           qspi_sck,
  input  logic           qspi_ncs,
  input  logic [3:0]     qspi_data_in,
  output logic [3:0]     qspi_data_out,
  output logic           qspi_data_out_en,
  output logic           quad_mode,
  output logic [ASZ-1:0] mem_addr,
  output logic           mem_wr_en,
  output logic [DSZ-1:0] mem_wr_data,
  output logic           mem_rd_en,
  input  logic [DSZ-1:0] mem_rd_data
);

  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(ADDR_NIBBLES - 1);
  localparam logic [CNT_W-1:0] DUMMY_CNT = CNT_W'(DUMMY);

  logic       w_rise, w_fall, w_ncs;
  logic [3:0] w_io;

  qspi_pin_sync u_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_sck      (qspi_sck),
    .i_ncs      (qspi_ncs),
    .i_data     (qspi_data_in),
    .o_sck_rise (w_rise),
    .o_sck_fall (w_fall),
    .o_ncs      (w_ncs),
    .o_data     (w_io)
  );

  qspi_state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [6:0]       r_shift;
  logic             r_quad, r_is_read, r_rd_cap;
  logic [ASZ-1:0]   r_addr;
  logic [DSZ-1:0]   r_wr_data, r_rd_word, r_out_word;
  logic             r_wr_en, r_rd_en, r_oe;
  logic [3:0]       r_dout;

  logic [7:0]     w_spi_byte, w_quad_byte;
  logic [1:0]     w_nib_idx, w_nib_nxt;
  logic [DSZ-1:0] w_src_word;

  assign w_spi_byte  = {r_shift, w_io[0]};
  assign w_quad_byte = {r_shift[3:0], w_io};
  assign w_nib_idx   = r_cnt[1:0];
  assign w_nib_nxt   = w_nib_idx + 2'd1;
  // Nibble 0 of each word comes from the freshly fetched/prefetched word.
  assign w_src_word  = (w_nib_idx == 2'd0) ? r_rd_word : r_out_word;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_CMD;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode; deselect overrides any edge seen in the same clk.
  always_comb begin
    w_state_nxt = r_state;
    if (w_ncs) begin
      w_state_nxt = ST_CMD;
    end else begin
      case (r_state)
        ST_CMD: if (w_rise) begin
          if (!r_quad && r_cnt == CNT_W'(7))
            w_state_nxt = ST_IGNORE;
          else if (r_quad && r_cnt == CNT_W'(1))
            w_state_nxt = (w_quad_byte == CMD_QREAD || w_quad_byte == CMD_QWRITE) ? ST_ADDR : ST_IGNORE;
        end
        ST_ADDR:  if (w_rise && r_cnt == LAST_ADDR) w_state_nxt = r_is_read ? ST_DUMMY : ST_WR_DATA;
        ST_DUMMY: if (w_fall && r_cnt == DUMMY_CNT) w_state_nxt = ST_RD_DATA;
        default:  ;
      endcase
    end
  end

  // Shift registers, counters, memory strobes and pad outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_shift    <= '0;
      r_quad     <= 1'b0;
      r_is_read  <= 1'b0;
      r_rd_cap   <= 1'b0;
      r_addr     <= '0;
      r_wr_data  <= '0;
      r_rd_word  <= '0;
      r_out_word <= '0;
      r_wr_en    <= 1'b0;
      r_rd_en    <= 1'b0;
      r_oe       <= 1'b0;
      r_dout     <= 4'h0;
    end else begin
      r_wr_en  <= 1'b0;
      r_rd_en  <= 1'b0;
      // Read data lands one clk after the strobe; drop it if deselected meanwhile.
      r_rd_cap <= r_rd_en & ~w_ncs;
      if (r_rd_cap) r_rd_word <= mem_rd_data;
      // Post-increment after a committed write.
      if (r_wr_en) r_addr <= r_addr + 1'b1;
      if (w_ncs) begin
        r_cnt <= '0;
        r_oe  <= 1'b0;
      end else begin
        case (r_state)
          ST_CMD: if (w_rise) begin
            r_cnt <= r_cnt + 1'b1;
            if (!r_quad) begin
              r_shift <= {r_shift[5:0], w_io[0]};
              if (r_cnt == CNT_W'(7)) begin
                r_cnt <= '0;
                if (w_spi_byte == CMD_ENTER_QUAD) r_quad <= 1'b1;
              end
            end else begin
              r_shift <= {r_shift[2:0], w_io};
              if (r_cnt == CNT_W'(1)) begin
                r_cnt     <= '0;
                r_is_read <= (w_quad_byte == CMD_QREAD);
              end
            end
          end
          ST_ADDR: if (w_rise) begin
            // Shifting straight into the address leaves the low ASZ bits after 6 nibbles.
            r_addr <= {r_addr[ASZ-5:0], w_io};
            r_cnt  <= r_cnt + 1'b1;
            if (r_cnt == LAST_ADDR) begin
              r_cnt   <= '0;
              r_rd_en <= r_is_read;
            end
          end
          ST_DUMMY: begin
            if (w_rise && r_cnt != DUMMY_CNT) r_cnt <= r_cnt + 1'b1;
            if (w_fall && r_cnt == DUMMY_CNT) begin
              r_oe       <= 1'b1;
              r_dout     <= r_rd_word[15:12];
              r_out_word <= r_rd_word;
              r_cnt      <= CNT_W'(1);
            end
          end
          ST_RD_DATA: if (w_fall) begin
            r_dout <= nib_sel(w_src_word, w_nib_idx);
            r_cnt  <= CNT_W'(w_nib_nxt);
            if (w_nib_idx == 2'd0) r_out_word <= r_rd_word;
            // Prefetch the next word while nibbles 1..3 go out.
            if (w_nib_idx == 2'd1) begin
              r_addr  <= r_addr + 1'b1;
              r_rd_en <= 1'b1;
            end
          end
          ST_WR_DATA: if (w_rise) begin
            r_wr_data <= {r_wr_data[11:0], w_io};
            if (r_cnt == CNT_W'(3)) begin
              r_cnt   <= '0;
              r_wr_en <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign qspi_data_out    = r_dout;
  assign qspi_data_out_en = r_oe;
  assign quad_mode        = r_quad;
  assign mem_addr         = r_addr;
  assign mem_wr_en        = r_wr_en;
  assign mem_wr_data      = r_wr_data;
  assign mem_rd_en        = r_rd_en;

endmodule

// File: tb/tb_qspi_psram_target.sv
// Directed bench for qspi_psram_target: SPI/quad commands, read/write streams, wrap, abort, reset.
module tb_qspi_psram_target;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        qspi_sck = 1'b0;
  logic        qspi_ncs = 1'b1;
  logic [3:0]  qspi_data_in = 4'h0;
  logic [3:0]  qspi_data_out;
  logic        qspi_data_out_en;
  logic        quad_mode;
  logic [21:0] mem_addr;
  logic        mem_wr_en, mem_rd_en;
  logic [15:0] mem_wr_data;
  logic [15:0] mem_rd_data = 16'h0;

  int n_chk = 0, n_err = 0;
  int wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
  logic [21:0] wr_addr_log [0:15];
  logic [15:0] wr_data_log [0:15];
  logic [3:0]  smp_q;
  logic        oe_any;

  qspi_psram_target dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .qspi_sck         (qspi_sck),
    .qspi_ncs         (qspi_ncs),
    .qspi_data_in     (qspi_data_in),
    .qspi_data_out    (qspi_data_out),
    .qspi_data_out_en (qspi_data_out_en),
    .quad_mode        (quad_mode),
    .mem_addr         (mem_addr),
    .mem_wr_en        (mem_wr_en),
    .mem_wr_data      (mem_wr_data),
    .mem_rd_en        (mem_rd_en),
    .mem_rd_data      (mem_rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rd_model(input logic [21:0] a);
    case (a)
      22'h10:  return 16'hA5C3;
      22'h11:  return 16'h1234;
      default: return 16'hDEAD;
    endcase
  endfunction

  // Memory model and strobe logger, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_wr_en) begin
      wr_addr_log[wr_cnt & 15] = mem_addr;
      wr_data_log[wr_cnt & 15] = mem_wr_data;
      wr_cnt = wr_cnt + 1;
    end
    if (mem_rd_en) begin
      mem_rd_data = rd_model(mem_addr);
      rd_cnt = rd_cnt + 1;
    end
    if (mem_wr_en && mem_rd_en) both_cnt = both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCK period at 8x oversampling; pads sampled just before the rise.
  task automatic pulse(input logic [3:0] d);
    qspi_data_in = d;
    clk_n(4);
    smp_q  = qspi_data_out;
    oe_any = oe_any | qspi_data_out_en;
    qspi_sck = 1'b1;
    clk_n(4);
    qspi_sck = 1'b0;
  endtask

  task automatic ncs_lo();
    qspi_ncs = 1'b0;
    oe_any = 1'b0;
    clk_n(4);
  endtask

  task automatic ncs_hi();
    clk_n(4);
    qspi_ncs = 1'b1;
    clk_n(8);
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) pulse({3'b000, b[i]});
  endtask

  task automatic quad_byte(input logic [7:0] b);
    pulse(b[7:4]);
    pulse(b[3:0]);
  endtask

  task automatic quad_hdr(input logic [7:0] cmd, input logic [23:0] a);
    quad_byte(cmd);
    quad_byte(a[23:16]);
    quad_byte(a[15:8]);
    quad_byte(a[7:0]);
  endtask

  task automatic quad_word(input logic [15:0] w);
    for (int i = 3; i >= 0; i--) pulse(w[4*i +: 4]);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_dout"},  qspi_data_out, 0);
    chk({pfx, "_oe"},    qspi_data_out_en, 0);
    chk({pfx, "_quad"},  quad_mode, 0);
    chk({pfx, "_addr"},  mem_addr, 0);
    chk({pfx, "_wren"},  mem_wr_en, 0);
    chk({pfx, "_rden"},  mem_rd_en, 0);
    chk({pfx, "_wdata"}, mem_wr_data, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w0, r0;
    logic [31:0] exp_nib;

    clk_n(3);
    chk_reset_vals("rst");
    reset_n = 1'b1;
    clk_n(4);

    // SPI enter-quad
    w0 = wr_cnt; r0 = rd_cnt;
    ncs_lo();
    spi_byte(8'h35);
    ncs_hi();
    chk("spi35_quad", quad_mode, 1);
    chk("spi35_strobes", (wr_cnt - w0) + (rd_cnt - r0), 0);

    // Quad write, two words from 0x10
    w0 = wr_cnt;
    ncs_lo();
    quad_hdr(8'h38, 24'h000010);
    quad_word(16'hA5C3);
    quad_word(16'h1234);
    ncs_hi();
    chk("wr_cnt", wr_cnt - w0, 2);
    chk("wr0_addr", wr_addr_log[w0 & 15], 32'h10);
    chk("wr0_data", wr_data_log[w0 & 15], 32'hA5C3);
    chk("wr1_addr", wr_addr_log[(w0 + 1) & 15], 32'h11);
    chk("wr1_data", wr_data_log[(w0 + 1) & 15], 32'h1234);
    chk("wr_addr_post", mem_addr, 32'h12);

    // Quad read from 0x10: nibbles on rises 14..21
    r0 = rd_cnt;
    ncs_lo();
    quad_hdr(8'hEB, 24'h000010);
    for (int i = 0; i < 6; i++) pulse(4'h0);
    chk("rd_oe_pre", oe_any, 0);
    exp_nib = 32'hA5C31234;
    for (int i = 7; i >= 0; i--) begin
      pulse(4'h0);
      chk($sformatf("rd_nib%0d", 7 - i), smp_q, exp_nib[4*i +: 4]);
    end
    chk("rd_oe_on", qspi_data_out_en, 1);
    ncs_hi();
    chk("rd_oe_off", qspi_data_out_en, 0);
    chk("rd_cnt", rd_cnt - r0, 3);
    chk("rd_addr_post", mem_addr, 32'h12);

    // Write wrap at the top of the address space
    w0 = wr_cnt;
    ncs_lo();
    quad_hdr(8'h38, 24'h3FFFFF);
    quad_word(16'hBEEF);
    quad_word(16'h0F0F);
    ncs_hi();
    chk("wrap_cnt", wr_cnt - w0, 2);
    chk("wrap0_addr", wr_addr_log[w0 & 15], 32'h3FFFFF);
    chk("wrap0_data", wr_data_log[w0 & 15], 32'hBEEF);
    chk("wrap1_addr", wr_addr_log[(w0 + 1) & 15], 32'h0);
    chk("wrap1_data", wr_data_log[(w0 + 1) & 15], 32'h0F0F);

    // Aborted write, then a normal one
    w0 = wr_cnt;
    ncs_lo();
    quad_hdr(8'h38, 24'h000020);
    pulse(4'hF);
    pulse(4'hE);
    ncs_hi();
    chk("abort_no_wr", wr_cnt - w0, 0);
    ncs_lo();
    quad_hdr(8'h38, 24'h000030);
    quad_word(16'h5A5A);
    ncs_hi();
    chk("after_abort_cnt", wr_cnt - w0, 1);
    chk("after_abort_addr", wr_addr_log[w0 & 15], 32'h30);
    chk("after_abort_data", wr_data_log[w0 & 15], 32'h5A5A);

    // Unknown quad command 0x9F is ignored
    w0 = wr_cnt; r0 = rd_cnt;
    ncs_lo();
    quad_byte(8'h9F);
    for (int i = 0; i < 8; i++) pulse(4'h0);
    ncs_hi();
    chk("ign9f_oe", oe_any, 0);
    chk("ign9f_strobes", (wr_cnt - w0) + (rd_cnt - r0), 0);

    // 0x35 in quad mode is an unknown quad command
    ncs_lo();
    quad_byte(8'h35);
    for (int i = 0; i < 8; i++) pulse(4'h0);
    ncs_hi();
    chk("ign35_oe", oe_any, 0);
    chk("ign35_quad", quad_mode, 1);
    chk("ign35_strobes", (wr_cnt - w0) + (rd_cnt - r0), 0);

    // Reset in the middle of a read stream
    ncs_lo();
    quad_hdr(8'hEB, 24'h000010);
    for (int i = 0; i < 8; i++) pulse(4'h0);
    chk("midrd_oe", qspi_data_out_en, 1);
    reset_n = 1'b0;
    clk_n(1);
    chk_reset_vals("midrd_rst");
    qspi_ncs = 1'b1;
    clk_n(4);
    reset_n = 1'b1;
    clk_n(4);

    chk("rd_wr_excl", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/qspi_psram_target.md
# qspi_psram_target

QSPI target (responder) that emulates the quad-mode PSRAM driven by the team's QSPI master. It recognises the 0x35 enter-quad, 0xEB quad-read and 0x38 quad-write transactions and maps them onto a simple synchronous word-memory port. The design instantiates it in simulation benches and in the loopback/self-test build, where it replaces the external PSRAM. All QSPI pins are oversampled in the `clk` domain.

## Interface

- `ASZ`, 22: word-address width; the on-wire address is 24 bits, upper `24-ASZ` bits ignored.
- `DSZ`, 16: data word width; fixed to 16 (4 nibbles per word).
- `DUMMY`, 6: quad-read wait cycles between address and data.

Ports:

- `clk` input 1: system clock; must be at least 8× the SCK frequency.
- `reset_n` input 1: asynchronous, active-low reset.
- `qspi_sck` input 1: serial clock from master, asynchronous.
- `qspi_ncs` input 1: chip select, active low, asynchronous.
- `qspi_data_in` input 4: IO[3:0] from pads; SPI mode uses IO0 only.
- `qspi_data_out` output 4: IO[3:0] driven to pads.
- `qspi_data_out_en` output 1: pad output enable.
- `quad_mode` output 1: 0x35 has been accepted.
- `mem_addr` output ASZ: word address for the current access.
- `mem_wr_en` output 1: one-`clk` write strobe.
- `mem_wr_data` output 16: write word.
- `mem_rd_en` output 1: one-`clk` read strobe.
- `mem_rd_data` input 16: read word, valid one `clk` after `mem_rd_en`.

## Operation

- Synchronise `qspi_sck`, `qspi_ncs` and `qspi_data_in` with 2-FF synchronisers. Detect SCK rise and fall from the synchronised copies.
- Sample IO on SCK rise. Update `qspi_data_out` on SCK fall.
- Synchronised NCS high is the idle condition. It forces the state to CMD, clears the nibble counter, deasserts `qspi_data_out_en` and discards any partial word.
- States:
  - CMD
  - ADDR
  - DUMMY
  - RD_DATA
  - WR_DATA
  - IGNORE
- CMD state:
  - SPI mode (`quad_mode`=0): take 8 bits from IO0, MSB first. 0x35 sets `quad_mode`, then go to IGNORE. Any other byte goes to IGNORE.
  - Quad mode: take 2 nibbles, MSB nibble first. 0xEB or 0x38 goes to ADDR; anything else goes to IGNORE.
- ADDR: take 6 nibbles, MSB first, and load `mem_addr` with bits [ASZ-1:0].
  - Read: pulse `mem_rd_en` one `clk` after the 6th nibble's rise, then go to DUMMY.
  - Write: go to WR_DATA.
- DUMMY: count `DUMMY` rises.
  - At the falling edge after the last dummy rise, assert `qspi_data_out_en`, drive nibble [15:12] of the fetched word, then go to RD_DATA.
- RD_DATA:
  - Each SCK fall shifts out the next nibble.
  - When the 2nd nibble of a word is driven, increment `mem_addr` and pulse `mem_rd_en` to prefetch the next word.
  - After the 4th nibble, the next fall loads the prefetched word.
  - The stream continues until NCS rises.
- WR_DATA:
  - Shift in 4 nibbles MSB first.
  - One `clk` after the 4th rise, pulse `mem_wr_en` with the current `mem_addr` and `mem_wr_data`.
  - Increment `mem_addr` one `clk` after the strobe.
- IGNORE: no output and no memory access until NCS rises.
- `quad_mode` is cleared only by reset. 0x35 received while in quad mode is an unknown quad command and goes to IGNORE.
- `mem_addr` wraps from 2^ASZ−1 to 0.
- An NCS rise mid-word: a write is not committed; a read prefetch that is already issued is discarded.

## Timing

- Reset values:
  - `qspi_data_out` = 0
  - `qspi_data_out_en` = 0
  - `quad_mode` = 0
  - `mem_addr` = 0
  - `mem_wr_en` = 0
  - `mem_rd_en` = 0
  - `mem_wr_data` = 0
  - State = CMD
- Input-to-action latency: 3 `clk` from the pin edge (2 synchroniser stages plus edge register).
  - Output nibbles are stable no later than 4 `clk` after the SCK fall. This is within the half period at 8× oversampling.
- Read transaction shape: SCK rises 0–7 carry command/address, rises 8–13 are dummy, and the first data nibble is sampled by the master on rise 14.
- `mem_rd_en` and `mem_wr_en` are never asserted in the same `clk`. Each is a single-`clk` pulse.
- An NCS rise and an SCK edge detected in the same `clk`: NCS wins and the edge is ignored.

## Structure

- Package `qspi_pkg`:
  - Command constants: `CMD_ENTER_QUAD`=0x35, `CMD_QREAD`=0xEB, `CMD_QWRITE`=0x38.
  - State enum.
  - `ADDR_NIBBLES`=6.
- Sub-module `qspi_pin_sync`: 2-FF synchronisers plus SCK rise/fall detection, reused by any other `clk`-domain QSPI logic.

## Test plan

- After reset, SPI 0x35 on IO0 → `quad_mode`=1 after NCS rises; no memory strobes.
- Quad write 0x38, addr 0x000010, words 0xA5C3, 0x1234 → `mem_wr_en` twice, at addr 0x10 with 0xA5C3 and at 0x11 with 0x1234.
- Quad read 0xEB, addr 0x000010, memory returns 0xA5C3, 0x1234 → nibbles A,5,C,3,1,2,3,4 sampled on rises 14–21; `qspi_data_out_en` low through rise 13.
- Write at addr 0x3FFFFF with 2 words → second write at addr 0x000000 (wrap).
- NCS rises after 2 data nibbles of a write → no `mem_wr_en`; the next transaction decodes normally.
- Quad-mode command 0x9F, then `reset_n` asserted mid-read → IGNORE with no outputs; on reset, all outputs return to reset values and `quad_mode`=0.
